// File: rtl/shift_pkg.sv
// Shift opcodes and opcode helpers shared by the pipelined barrel shifter.
// Pure declarations: no logic, no latency, no flow control.
package shift_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } shift_op_e;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return op inside {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR};
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel level: shift/rotate by 2**LEVEL when shamt[LEVEL] is set, then a valid/ready register.
// One cycle latency; holds its contents while valid and downstream is not ready.
module shift_stage
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int LEVEL = 0,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic [SHW-1:0]   src_shamt,
  input  logic [OP_W-1:0]  src_op,
  input  logic             src_carry,
  input  logic             src_illegal,
  input  logic             dst_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [SHW-1:0]   shamt,
  output logic [OP_W-1:0]  op,
  output logic             carry,
  output logic             illegal
);

  localparam int AMT = 1 << LEVEL;

  logic [WIDTH-1:0] nxt;
  logic             load;

  always_comb begin
    nxt = src_data;
    if (src_shamt[LEVEL]) begin
      case (shift_op_e'(src_op))
        OP_SLL:  nxt = src_data << AMT;
        OP_SRL:  nxt = src_data >> AMT;
        OP_SRA:  nxt = WIDTH'($signed(src_data) >>> AMT);
        OP_ROL:  nxt = (src_data << AMT) | (src_data >> (WIDTH - AMT));
        OP_ROR:  nxt = (src_data >> AMT) | (src_data << (WIDTH - AMT));
        default: nxt = src_data;
      endcase
    end
  end

  assign load = !valid || dst_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      data    <= '0;
      shamt   <= '0;
      op      <= '0;
      carry   <= 1'b0;
      illegal <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= src_valid;
      if (src_valid) begin
        data    <= nxt;
        shamt   <= src_shamt;
        op      <= src_op;
        carry   <= src_carry;
        illegal <= src_illegal;
      end
    end
  end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter/rotator with carry, zero and illegal-op flags, one level per stage.
// Latency $clog2(WIDTH) cycles, 1 op/cycle; stalls propagate back combinationally, flush drops all in flight.
module pipe_barrel_shifter
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_illegal
);

  logic [SHW-1:0]   vld;
  logic [SHW:0]     rdy;
  logic [WIDTH-1:0] dat [SHW];
  logic [SHW-1:0]   sha [SHW];
  logic [OP_W-1:0]  opc [SHW];
  logic [SHW-1:0]   cry;
  logic [SHW-1:0]   ill;

  logic [SHW-1:0] idx_l;
  logic [SHW-1:0] idx_r;
  logic           carry_in;

  // Carry is taken from the original operand: WIDTH-shamt wraps to -shamt in SHW bits.
  assign idx_l = '0 - in_shamt;
  assign idx_r = in_shamt - SHW'(1);

  always_comb begin
    carry_in = 1'b0;
    if (in_shamt != '0) begin
      case (shift_op_e'(in_op))
        OP_SLL:         carry_in = in_data[idx_l];
        OP_SRL, OP_SRA: carry_in = in_data[idx_r];
        default:        carry_in = 1'b0;
      endcase
    end
  end

  // Stage k can load iff some stage at or after k is empty, or the consumer takes the result.
  assign rdy[SHW] = out_ready;

  genvar k;
  for (k = 0; k < SHW; k++) begin : g_stage
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic [SHW-1:0]   s_shamt;
    logic [OP_W-1:0]  s_op;
    logic             s_carry;
    logic             s_illegal;

    assign rdy[k] = out_ready | ~&vld[SHW-1:k];

    if (k == 0) begin : g_first
      assign s_valid   = in_valid;
      assign s_data    = in_data;
      assign s_shamt   = in_shamt;
      assign s_op      = in_op;
      assign s_carry   = carry_in;
      assign s_illegal = !is_legal_op(in_op);
    end else begin : g_next
      assign s_valid   = vld[k-1];
      assign s_data    = dat[k-1];
      assign s_shamt   = sha[k-1];
      assign s_op      = opc[k-1];
      assign s_carry   = cry[k-1];
      assign s_illegal = ill[k-1];
    end

    shift_stage #(
      .WIDTH(WIDTH),
      .LEVEL(k)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .src_valid   (s_valid),
      .src_data    (s_data),
      .src_shamt   (s_shamt),
      .src_op      (s_op),
      .src_carry   (s_carry),
      .src_illegal (s_illegal),
      .dst_ready   (rdy[k+1]),
      .valid       (vld[k]),
      .data        (dat[k]),
      .shamt       (sha[k]),
      .op          (opc[k]),
      .carry       (cry[k]),
      .illegal     (ill[k])
    );
  end

  assign in_ready    = !flush && rdy[0];
  assign out_valid   = vld[SHW-1];
  assign out_data    = dat[SHW-1];
  assign out_carry   = cry[SHW-1];
  assign out_illegal = ill[SHW-1];
  assign out_zero    = vld[SHW-1] && (dat[SHW-1] == '0);

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Directed and randomized checks of the 8-bit pipelined barrel shifter.
module tb_pipe_barrel_shifter;
  localparam int W  = 8;
  localparam int SH = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SH-1:0] in_shamt = '0;
  logic [2:0]    in_op = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_carry;
  logic          out_zero;
  logic          out_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_barrel_shifter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_shamt    (in_shamt),
    .in_op       (in_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_carry   (out_carry),
    .out_zero    (out_zero),
    .out_illegal (out_illegal)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drives one op, waits for it to be accepted and for its result; lat counts edges from accept edge.
  task automatic run_one(input logic [2:0] op, input logic [7:0] d, input logic [2:0] sh,
                         output logic [7:0] rd, output logic rc, output logic rz,
                         output logic ri, output int lat);
    lat = 99;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_data = d; in_shamt = sh;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = i; break; end
      @(posedge clk); #1;
    end
    rd = out_data; rc = out_carry; rz = out_zero; ri = out_illegal;
  endtask

  task automatic model(input logic [2:0] op, input logic [7:0] d, input logic [2:0] sh,
                       output logic [7:0] r, output logic c, output logic il);
    r = d; c = 1'b0; il = 1'b0;
    for (int i = 0; i < int'(sh); i++) begin
      case (op)
        3'd0: begin c = r[7]; r = {r[6:0], 1'b0}; end
        3'd1: begin c = r[0]; r = {1'b0, r[7:1]}; end
        3'd2: begin c = r[0]; r = {r[7], r[7:1]}; end
        3'd3: r = {r[6:0], r[7]};
        3'd4: r = {r[0], r[7:1]};
        default: ;
      endcase
    end
    if (op > 3'd4) il = 1'b1;
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({out_valid, out_data, out_carry, out_zero, out_illegal} !== 12'h000) begin
      bad++;
      $display("FAIL reset_init: got v=%b d=%h c=%b z=%b i=%b want all zero",
               out_valid, out_data, out_carry, out_zero, out_illegal);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready0: got %b want 1", in_ready); end
    // Two ops go in, then reset lands mid-stream.
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 3'd0; in_data = 8'hFF; in_shamt = 3'd1;
    @(posedge clk); #1;
    in_data = 8'h7F;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({out_valid, out_data, out_carry, out_zero, out_illegal} !== 12'h000) begin
      bad++;
      $display("FAIL reset_mid: got v=%b d=%h c=%b z=%b i=%b want all zero",
               out_valid, out_data, out_carry, out_zero, out_illegal);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL reset_no_partial: got %0d results want 0", seen); end
  endtask

  task automatic test_sra();
    logic [7:0] rd; logic rc, rz, ri; int lat;
    run_one(3'd2, 8'h96, 3'd3, rd, rc, rz, ri, lat);
    total++;
    if (rd !== 8'hF2) begin bad++; $display("FAIL sra_data: got %h want f2", rd); end
    total++;
    if (rc !== 1'b1) begin bad++; $display("FAIL sra_carry: got %b want 1", rc); end
    total++;
    if (rz !== 1'b0) begin bad++; $display("FAIL sra_zero: got %b want 0", rz); end
    total++;
    if (lat != SH) begin bad++; $display("FAIL sra_latency: got %0d want %0d", lat, SH); end
  endtask

  task automatic test_ops();
    logic [2:0] ops [4] = '{3'd3, 3'd4, 3'd0, 3'd1};
    logic [7:0] din [4] = '{8'hA5, 8'hA5, 8'h03, 8'h01};
    logic [2:0] shs [4] = '{3'd1, 3'd1, 3'd7, 3'd1};
    logic [7:0] exd [4] = '{8'h4B, 8'hD2, 8'h80, 8'h00};
    logic       exc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       exz [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] rd; logic rc, rz, ri; int lat;
    for (int i = 0; i < 4; i++) begin
      run_one(ops[i], din[i], shs[i], rd, rc, rz, ri, lat);
      total++;
      if ({rd, rc, rz, ri} !== {exd[i], exc[i], exz[i], 1'b0}) begin
        bad++;
        $display("FAIL ops_%0d: got d=%h c=%b z=%b i=%b want d=%h c=%b z=%b i=0",
                 i, rd, rc, rz, ri, exd[i], exc[i], exz[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [7:0] rd; logic rc, rz, ri; int lat;
    run_one(3'b111, 8'h5A, 3'd2, rd, rc, rz, ri, lat);
    total++;
    if ({rd, rc, ri} !== {8'h5A, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL illegal_111: got d=%h c=%b i=%b want d=5a c=0 i=1", rd, rc, ri);
    end
    run_one(3'b101, 8'h81, 3'd3, rd, rc, rz, ri, lat);
    total++;
    if ({rd, rc, ri} !== {8'h81, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL illegal_101: got d=%h c=%b i=%b want d=81 c=0 i=1", rd, rc, ri);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [6] = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C};
    int sent = 0, rcv = 0, first_block = -1;
    logic held_v = 1'b0, acc;
    logic [7:0] held_d = '0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd0; in_shamt = 3'd1; in_data = 8'h01;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (in_valid && !in_ready && first_block < 0) first_block = sent;
      if (held_v) begin
        total++;
        if (!out_valid || out_data !== held_d) begin
          bad++;
          $display("FAIL bp_hold: got v=%b d=%h want v=1 d=%h", out_valid, out_data, held_d);
        end
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      if (out_valid && out_ready) begin
        total++;
        if (rcv >= 6 || out_data !== exp[rcv]) begin
          bad++;
          $display("FAIL bp_order: result %0d got %h want %h", rcv, out_data, (rcv < 6) ? exp[rcv] : 8'hxx);
        end
        rcv++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 6) in_data = 8'(sent + 1);
        else in_valid = 1'b0;
      end
      out_ready = (c >= 4);
    end
    total++;
    if (first_block != 3) begin bad++; $display("FAIL bp_block: in_ready fell after %0d accepts want 3", first_block); end
    total++;
    if (rcv != 6) begin bad++; $display("FAIL bp_count: got %0d results want 6", rcv); end
    out_ready = 1'b1;
  endtask

  task automatic test_flush();
    int seen = 0;
    logic [7:0] rd; logic rc, rz, ri; int lat;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd3; in_shamt = 3'd1; in_data = 8'h11;
    repeat (3) begin
      @(posedge clk); #1;
      in_data = in_data + 8'h11;
    end
    flush = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL flush_drop: got %0d results want 0", seen); end
    run_one(3'd3, 8'h81, 3'd1, rd, rc, rz, ri, lat);
    total++;
    if (rd !== 8'h03 || lat != SH) begin
      bad++;
      $display("FAIL flush_next: got d=%h lat=%0d want d=03 lat=%0d", rd, lat, SH);
    end
  endtask

  task automatic test_random();
    logic [7:0] rd, er; logic rc, rz, ri, ec, ei; int lat;
    logic [2:0] op, sh; logic [7:0] d;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(7, 0));
      sh = 3'($urandom_range(7, 0));
      d  = 8'($urandom_range(255, 0));
      model(op, d, sh, er, ec, ei);
      run_one(op, d, sh, rd, rc, rz, ri, lat);
      total++;
      if ({rd, rc, rz, ri} !== {er, ec, (er == 8'h00), ei} || lat != SH) begin
        bad++;
        $display("FAIL rand_%0d op=%0d d=%h sh=%0d: got d=%h c=%b z=%b i=%b lat=%0d want d=%h c=%b z=%b i=%b",
                 n, op, d, sh, rd, rc, rz, ri, lat, er, ec, (er == 8'h00), ei);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sra();
    test_ops();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
